// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the cross-domain memory command path.
//   - Command word layout: [16] op, [15:8] address, [7:0] write data.
//   - Sequencer state encoding.
//   - pack_cmd(): builds a command word from its fields.
package mem_cmd_pkg;

  localparam int CMD_W    = 17;
  localparam int OP_BIT   = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic CMD_OP_WRITE = 1'b1;
  localparam logic CMD_OP_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RESP,
    NEXT,
    DONE
  } seq_state_e;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic       op,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
    logic [CMD_W-1:0] cmd;
    cmd                    = '0;
    cmd[OP_BIT]            = op;
    cmd[ADDR_MSB:ADDR_LSB] = addr;
    cmd[DATA_MSB:0]        = data;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_rw_sequencer.sv
// Test master for the cross-domain memory path (fast clock domain).
// On a rising edge of start_operations it pushes NUM_OPS write/read pairs
// into the command FIFO, pops each read response and compares it with the
// data written. busy covers the whole run; operation_success is sticky
// until the next start or reset.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   start_operations  start request (edge detected internally)
//   cmd_fifo_wr_en    command push strobe
//   cmd_fifo_data     17-bit command word {op, addr, data}
//   cmd_fifo_full     command FIFO full
//   resp_fifo_rd_en   response pop strobe
//   resp_fifo_data    response byte (first-word-fall-through)
//   resp_fifo_empty   response FIFO empty
//   busy              run in progress
//   debug_data        last response byte popped
//   operation_success result of the last completed run
module mem_rw_sequencer
  import mem_cmd_pkg::*;
#(
  parameter int         NUM_OPS      = 8,
  parameter logic [7:0] ADDR_BASE    = 8'h00,
  parameter logic [7:0] DATA_SEED    = 8'hA5,
  parameter int         RESP_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_operations,
  output logic             cmd_fifo_wr_en,
  output logic [CMD_W-1:0] cmd_fifo_data,
  input  logic             cmd_fifo_full,
  output logic             resp_fifo_rd_en,
  input  logic [7:0]       resp_fifo_data,
  input  logic             resp_fifo_empty,
  output logic             busy,
  output logic [7:0]       debug_data,
  output logic             operation_success
);

  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);

  seq_state_e       state;
  logic [IDX_W-1:0] idx;
  logic             mismatch;
  logic [TO_W-1:0]  to_cnt;
  logic             start_q, start_q2;
  logic             start_edge;
  logic [7:0]       addr_i, data_i;

  assign start_edge = start_q & ~start_q2;

  // Address wraps modulo 256 through the 8-bit add.
  assign addr_i = ADDR_BASE + 8'(idx);
  assign data_i = addr_i ^ DATA_SEED;

  assign busy = (state != IDLE);

  // Strobes are a pure function of state and FIFO flags so they can never
  // fire against a full/empty FIFO, and push/pop live in disjoint states.
  always_comb begin
    cmd_fifo_wr_en  = 1'b0;
    resp_fifo_rd_en = 1'b0;
    cmd_fifo_data   = '0;
    case (state)
      ISSUE_WR: begin
        cmd_fifo_wr_en = ~cmd_fifo_full;
        cmd_fifo_data  = pack_cmd(CMD_OP_WRITE, addr_i, data_i);
      end
      ISSUE_RD: begin
        cmd_fifo_wr_en = ~cmd_fifo_full;
        cmd_fifo_data  = pack_cmd(CMD_OP_READ, addr_i, 8'h00);
      end
      WAIT_RESP: resp_fifo_rd_en = ~resp_fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      mismatch          <= 1'b0;
      to_cnt            <= '0;
      start_q           <= 1'b0;
      start_q2          <= 1'b0;
      debug_data        <= 8'h00;
      operation_success <= 1'b0;
    end else begin
      start_q  <= start_operations;
      start_q2 <= start_q;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state             <= ISSUE_WR;
            idx               <= '0;
            mismatch          <= 1'b0;
            operation_success <= 1'b0;
          end
        end
        ISSUE_WR: begin
          if (!cmd_fifo_full) state <= ISSUE_RD;
        end
        ISSUE_RD: begin
          if (!cmd_fifo_full) begin
            state  <= WAIT_RESP;
            to_cnt <= '0;
          end
        end
        WAIT_RESP: begin
          if (!resp_fifo_empty) begin
            debug_data <= resp_fifo_data;
            if (resp_fifo_data != data_i) mismatch <= 1'b1;
            state <= NEXT;
          end else if (to_cnt == TO_W'(RESP_TIMEOUT - 1)) begin
            // Counter would reach RESP_TIMEOUT on this edge: abort the run.
            to_cnt   <= to_cnt + 1'b1;
            mismatch <= 1'b1;
            state    <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx == IDX_W'(NUM_OPS - 1)) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE_WR;
          end
        end
        DONE: begin
          operation_success <= ~mismatch;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rw_sequencer.sv
// Bench for mem_rw_sequencer: an ideal command FIFO + memory + response FIFO
// model with random stalls and response latency, a strobe-rule monitor and
// directed scenarios checked against the expected command stream.
module tb_mem_rw_sequencer;

  localparam int         N    = 8;
  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         TMO  = 40;

  logic        clk;
  logic        rst;
  logic        start_operations;
  logic        cmd_fifo_wr_en;
  logic [16:0] cmd_fifo_data;
  logic        cmd_fifo_full;
  logic        resp_fifo_rd_en;
  logic [7:0]  resp_fifo_data;
  logic        resp_fifo_empty;
  logic        busy;
  logic [7:0]  debug_data;
  logic        operation_success;

  mem_rw_sequencer #(
    .NUM_OPS(N), .ADDR_BASE(BASE), .DATA_SEED(SEED), .RESP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start_operations(start_operations),
    .cmd_fifo_wr_en(cmd_fifo_wr_en), .cmd_fifo_data(cmd_fifo_data),
    .cmd_fifo_full(cmd_fifo_full), .resp_fifo_rd_en(resp_fifo_rd_en),
    .resp_fifo_data(resp_fifo_data), .resp_fifo_empty(resp_fifo_empty),
    .busy(busy), .debug_data(debug_data), .operation_success(operation_success)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  typedef struct { logic [7:0] d; int rdy; } resp_t;
  logic [7:0]  mem [256];
  resp_t       rq[$];
  logic [16:0] push_log[$];
  int pops = 0, viol = 0, outstanding = 0, cyc = 0;
  int first_rd_cyc = -1, fall_cyc = -1, run_cnt = 0;
  int corrupt_addr = -1;
  bit no_resp = 0, rand_full = 0, force_full = 0, busy_q = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    cmd_fifo_full   = 1'b0;
    resp_fifo_empty = 1'b1;
    resp_fifo_data  = 8'h00;
  end

  // FIFO-side drivers: update just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    cmd_fifo_full = force_full || (rand_full && ($urandom_range(0, 2) == 0));
    if (rq.size() > 0 && rq[0].rdy <= cyc) begin
      resp_fifo_empty = 1'b0;
      resp_fifo_data  = rq[0].d;
    end else begin
      resp_fifo_empty = 1'b1;
      resp_fifo_data  = 8'($urandom);
    end
  end

  // Monitor: strobes sampled here are the ones the DUT acts on next edge.
  resp_t r;
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      busy_q      = 1'b0;
    end else begin
      if (cmd_fifo_wr_en) begin
        if (cmd_fifo_full) viol++;
        if (cmd_fifo_data[16] && outstanding != 0) viol++;
        push_log.push_back(cmd_fifo_data);
        if (cmd_fifo_data[16]) begin
          mem[cmd_fifo_data[15:8]] = cmd_fifo_data[7:0];
        end else begin
          outstanding++;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          if (!no_resp) begin
            r.d   = (int'(cmd_fifo_data[15:8]) == corrupt_addr) ? 8'h00
                                                                : mem[cmd_fifo_data[15:8]];
            r.rdy = cyc + $urandom_range(1, 4);
            rq.push_back(r);
          end
        end
      end
      if (resp_fifo_rd_en) begin
        if (resp_fifo_empty || rq.size() == 0) viol++;
        else begin
          void'(rq.pop_front());
          pops++;
          outstanding--;
        end
      end
      if (cmd_fifo_wr_en && resp_fifo_rd_en) viol++;
      if (busy && !busy_q) run_cnt++;
      if (!busy && busy_q) fall_cyc = cyc;
      busy_q = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k-th expected push of a run: even = write of pair k/2, odd = its read.
  function automatic logic [16:0] exp_word(input int k);
    logic [7:0] a;
    a = BASE + 8'(k / 2);
    return (k % 2 == 0) ? {1'b1, a, a ^ SEED} : {1'b0, a, 8'h00};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    push_log.delete();
    rq.delete();
    pops = 0; viol = 0;
    first_rd_cyc = -1; fall_cyc = -1;
  endtask

  task automatic pulse_start();
    start_operations = 1'b1;
    tick(2);
    start_operations = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy !== 1'b1 && k < 20) begin tick(); k++; end
    while (busy !== 1'b0 && k < budget) begin tick(); k++; end
    check({tag, "_done_in_budget"}, (k < budget), 1);
  endtask

  task automatic check_run(input string tag, input int npairs, input bit succ,
                           input logic [7:0] dbg);
    int n;
    check({tag, "_npush"}, push_log.size(), 2 * npairs);
    n = (push_log.size() < 2 * npairs) ? push_log.size() : 2 * npairs;
    for (int k = 0; k < n; k++)
      check($sformatf("%s_push%0d", tag, k), push_log[k], exp_word(k));
    check({tag, "_strobe_rules"}, viol, 0);
    check({tag, "_success"}, operation_success, succ);
    check({tag, "_debug"}, debug_data, dbg);
  endtask

  initial begin
    int rc;
    logic [7:0] last_d;
    last_d = (BASE + 8'(N - 1)) ^ SEED;
    rst = 1'b1;
    start_operations = 1'b0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_wr_en", cmd_fifo_wr_en, 0);
    check("rst_rd_en", resp_fifo_rd_en, 0);
    check("rst_cmd_data", cmd_fifo_data, 0);
    check("rst_debug", debug_data, 0);
    check("rst_success", operation_success, 0);
    rst = 1'b0;
    tick(2);

    // Basic run, no stalls.
    clear_model();
    rc = run_cnt;
    pulse_start();
    wait_idle("basic", 500);
    check_run("basic", N, 1'b1, last_d);
    check("basic_one_run", run_cnt, rc + 1);

    // Command FIFO held full at the first write.
    clear_model();
    force_full = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_busy%0d", i), busy, 1);
      check($sformatf("stall_wr_en%0d", i), cmd_fifo_wr_en, 0);
      check($sformatf("stall_data%0d", i), cmd_fifo_data, exp_word(0));
      tick();
    end
    force_full = 1'b0;
    wait_idle("stall", 500);
    check_run("stall", N, 1'b1, last_d);

    // Random stalls and response latencies.
    rand_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      clear_model();
      pulse_start();
      wait_idle($sformatf("rand%0d", j), 1000);
      check_run($sformatf("rand%0d", j), N, 1'b1, last_d);
    end
    rand_full = 1'b0;

    // Corrupted response for pair 3.
    clear_model();
    corrupt_addr = int'(BASE) + 3;
    pulse_start();
    wait_idle("corrupt", 500);
    check_run("corrupt", N, 1'b0, last_d);
    corrupt_addr = -1;

    // No response ever: timeout abort.
    clear_model();
    no_resp = 1'b1;
    pulse_start();
    wait_idle("tmo", TMO + 100);
    check_run("tmo", 1, 1'b0, last_d);
    check("tmo_no_pops", pops, 0);
    check("tmo_busy_fall", fall_cyc - first_rd_cyc, TMO + 2);

    // Reset while waiting for a response.
    clear_model();
    pulse_start();
    for (int k = 0; k < 50 && first_rd_cyc < 0; k++) tick();
    tick(3);
    check("mid_in_run", busy, 1);
    rst = 1'b1;
    tick();
    check("mid_busy", busy, 0);
    check("mid_wr_en", cmd_fifo_wr_en, 0);
    check("mid_rd_en", resp_fifo_rd_en, 0);
    check("mid_cmd_data", cmd_fifo_data, 0);
    check("mid_success", operation_success, 0);
    check("mid_debug", debug_data, 0);
    rst = 1'b0;
    no_resp = 1'b0;
    tick(2);
    clear_model();
    pulse_start();
    wait_idle("post_rst", 500);
    check_run("post_rst", N, 1'b1, last_d);

    // start held high: one run only until a fresh edge.
    clear_model();
    rc = run_cnt;
    start_operations = 1'b1;
    wait_idle("held", 500);
    tick(30);
    check("held_runs", run_cnt, rc + 1);
    check("held_idle", busy, 0);
    check_run("held", N, 1'b1, last_d);
    start_operations = 1'b0;
    tick(3);
    check("held_low_runs", run_cnt, rc + 1);
    clear_model();
    pulse_start();
    wait_idle("rearm", 500);
    check("rearm_runs", run_cnt, rc + 2);
    check_run("rearm", N, 1'b1, last_d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
